// File: rtl/collision_scorer.sv
// rtl/collision_scorer.sv - per-frame object/hammer hit-miss scorer with respawn handshake
module collision_scorer #(
    parameter int OBJ_W       = 32,
    parameter int OBJ_H       = 32,
    parameter int HAM_W       = 24,
    parameter int HAM_H       = 24,
    parameter int MISS_Y      = 480,
    parameter int SCORE_W     = 10,
    parameter int MISS_LIMIT  = 3,
    parameter int COOL_FRAMES = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic [9:0]         obj_x,
    input  logic [8:0]         obj_y,
    input  logic               obj_active,
    input  logic [9:0]         ham_x,
    input  logic [8:0]         ham_y,
    input  logic               ham_swing,
    input  logic               respawn_ack,
    input  logic               restart,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               respawn_req,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         misses,
    output logic               game_over
);
    localparam int CW = $clog2(COOL_FRAMES + 1);

    typedef enum logic [2:0] {IDLE, CHECK, TAG, WAIT_ACK, COOL, OVER} state_t;

    state_t        state, state_nx;
    logic [9:0]    s_obj_x, s_ham_x;
    logic [8:0]    s_obj_y, s_ham_y;
    logic          s_active, s_swing;
    logic          tag_hit;
    logic [CW-1:0] cool_cnt;

    logic [10:0] ox, oy, hx, hy;
    logic        overlap, hit, miss;

    // Zero-extended to 11 bits so edge sums near the screen limit never wrap.
    assign ox = {1'b0, s_obj_x};
    assign hx = {1'b0, s_ham_x};
    assign oy = {2'b0, s_obj_y};
    assign hy = {2'b0, s_ham_y};

    assign overlap = (ox < hx + 11'(HAM_W)) && (hx < ox + 11'(OBJ_W)) &&
                     (oy < hy + 11'(HAM_H)) && (hy < oy + 11'(OBJ_H));
    assign hit     = s_active && s_swing && overlap;
    assign miss    = s_active && (oy > 11'(MISS_Y)) && !hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (frame_tick) state_nx = CHECK;
            CHECK:    state_nx = (hit || miss) ? TAG : IDLE;
            TAG:      state_nx = WAIT_ACK;
            WAIT_ACK: if (respawn_ack) state_nx = (misses == 2'(MISS_LIMIT)) ? OVER : COOL;
            COOL:     if (frame_tick && cool_cnt <= CW'(1)) state_nx = IDLE;
            OVER:     state_nx = OVER;
            default:  state_nx = IDLE;
        endcase
        if (restart) state_nx = IDLE;
    end

    always_comb begin
        hit_pulse  = (state == TAG) && tag_hit;
        miss_pulse = (state == TAG) && !tag_hit;
        game_over  = (state == OVER);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_obj_x     <= '0;
            s_obj_y     <= '0;
            s_ham_x     <= '0;
            s_ham_y     <= '0;
            s_active    <= 1'b0;
            s_swing     <= 1'b0;
            tag_hit     <= 1'b0;
            score       <= '0;
            misses      <= '0;
            respawn_req <= 1'b0;
            cool_cnt    <= '0;
        end else if (restart) begin
            score       <= '0;
            misses      <= '0;
            respawn_req <= 1'b0;
            cool_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (frame_tick) begin
                    s_obj_x  <= obj_x;
                    s_obj_y  <= obj_y;
                    s_ham_x  <= ham_x;
                    s_ham_y  <= ham_y;
                    s_active <= obj_active;
                    s_swing  <= ham_swing;
                end
                // Counters and the request update here so they are already visible in TAG.
                CHECK: begin
                    tag_hit <= hit;
                    if (hit && score != {SCORE_W{1'b1}})
                        score <= score + 1'b1;
                    if (miss && misses < 2'(MISS_LIMIT))
                        misses <= misses + 1'b1;
                    if (hit || miss)
                        respawn_req <= 1'b1;
                end
                WAIT_ACK: if (respawn_ack) begin
                    respawn_req <= 1'b0;
                    cool_cnt    <= CW'(COOL_FRAMES);
                end
                COOL: if (frame_tick && cool_cnt != '0)
                    cool_cnt <= cool_cnt - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_scorer.sv
// tb/tb_collision_scorer.sv - scoreboard bench for collision_scorer
module tb_collision_scorer;
    logic       clk = 1'b0;
    logic       resetn, frame_tick, obj_active, ham_swing, respawn_ack, restart;
    logic [9:0] obj_x, ham_x;
    logic [8:0] obj_y, ham_y;
    logic       hit_pulse, miss_pulse, respawn_req, game_over;
    logic [9:0] score;
    logic [1:0] misses;

    collision_scorer dut (
        .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
        .obj_x(obj_x), .obj_y(obj_y), .obj_active(obj_active),
        .ham_x(ham_x), .ham_y(ham_y), .ham_swing(ham_swing),
        .respawn_ack(respawn_ack), .restart(restart),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .respawn_req(respawn_req),
        .score(score), .misses(misses), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic hit;
        int   sc;
        int   ms;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_score  = 0;
    int   exp_misses = 0;
    logic prev_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && (hit_pulse || miss_pulse)) begin
            exp_t e;
            if (hit_pulse && miss_pulse) check("both_pulses", 1, 0);
            if (prev_pulse) check("back_to_back_pulse", 1, 0);
            if (sbq.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("sb_kind", hit_pulse, e.hit);
                check("sb_score", score, e.sc);
                check("sb_misses", misses, e.ms);
            end
        end
        prev_pulse = hit_pulse || miss_pulse;
    end

    task automatic set_geom(input int ox, input int oy, input logic act,
                            input int hx, input int hy, input logic sw);
        obj_x = 10'(ox); obj_y = 9'(oy); obj_active = act;
        ham_x = 10'(hx); ham_y = 9'(hy); ham_swing = sw;
    endtask

    // kind: 0 = no tag expected, 1 = hit, 2 = miss
    task automatic frame(input int kind);
        if (kind == 1) begin
            if (exp_score < 1023) exp_score++;
            sbq.push_back('{1'b1, exp_score, exp_misses});
        end else if (kind == 2) begin
            if (exp_misses < 3) exp_misses++;
            sbq.push_back('{1'b0, exp_score, exp_misses});
        end
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #1;
        check("hit_pulse_at_tag", hit_pulse, kind == 1);
        check("miss_pulse_at_tag", miss_pulse, kind == 2);
        check("respawn_req_at_tag", respawn_req, kind != 0);
    endtask

    task automatic do_ack();
        respawn_ack = 1'b1;
        for (int i = 0; i < 20 && respawn_req; i++) begin
            @(posedge clk); #1;
        end
        check("respawn_req_drop", respawn_req, 0);
        respawn_ack = 1'b0;
    endtask

    task automatic cool(input int n);
        frame_tick = 1'b1;
        repeat (n) @(posedge clk);
        #1 frame_tick = 1'b0;
    endtask

    task automatic do_restart();
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
        exp_score = 0; exp_misses = 0;
        check("restart_score", score, 0);
        check("restart_misses", misses, 0);
        check("restart_game_over", game_over, 0);
        check("restart_respawn_req", respawn_req, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; frame_tick = 1'b0; respawn_ack = 1'b0; restart = 1'b0;
        set_geom(100, 200, 1'b1, 110, 210, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit_pulse", hit_pulse, 0);
        check("rst_miss_pulse", miss_pulse, 0);
        check("rst_respawn_req", respawn_req, 0);
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);
        check("rst_game_over", game_over, 0);
        resetn = 1'b1;

        // basic hit, request held until acknowledged
        frame(1);
        repeat (3) @(posedge clk);
        #1 check("respawn_req_held", respawn_req, 1);
        do_ack();
        cool(15);

        // no swing, then right edge just touching, then one pixel of overlap
        set_geom(100, 200, 1'b1, 110, 210, 1'b0);
        frame(0);
        set_geom(100, 200, 1'b1, 132, 210, 1'b1);
        frame(0);
        check("score_after_no_hit", score, exp_score);
        set_geom(100, 200, 1'b1, 131, 210, 1'b1);
        frame(1);
        do_ack();
        cool(15);

        // escape below screen vs exactly on the limit
        set_geom(300, 481, 1'b1, 10, 10, 1'b1);
        frame(2);
        do_ack();
        cool(15);
        set_geom(300, 480, 1'b1, 10, 10, 1'b1);
        frame(0);
        set_geom(300, 481, 1'b0, 10, 10, 1'b1);
        frame(0);

        // hit beats miss; cooldown consumes exactly COOL_FRAMES ticks
        set_geom(100, 481, 1'b1, 110, 470, 1'b1);
        frame(1);
        check("misses_after_hit_wins", misses, exp_misses);
        do_ack();
        cool(14);
        frame(0);
        frame(1);
        do_ack();
        cool(15);

        // three misses end the game
        do_restart();
        set_geom(300, 481, 1'b1, 10, 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            frame(2);
            do_ack();
            if (i < 2) cool(15);
        end
        check("game_over_set", game_over, 1);
        frame(0);
        set_geom(100, 200, 1'b1, 110, 210, 1'b1);
        frame(0);
        check("game_over_sticky", game_over, 1);
        check("score_frozen_over", score, 0);
        do_restart();

        // score saturation
        respawn_ack = 1'b0;
        while (exp_score < 1023) begin
            frame(1);
            do_ack();
            cool(15);
        end
        frame(1);
        check("score_saturated", score, 1023);

        // async reset while the respawn request is pending
        @(posedge clk); #2 resetn = 1'b0;
        #1;
        check("async_rst_respawn_req", respawn_req, 0);
        check("async_rst_score", score, 0);
        check("async_rst_hit_pulse", hit_pulse, 0);
        @(posedge clk); #1 resetn = 1'b1;
        exp_score = 0; exp_misses = 0;
        repeat (2) @(posedge clk);
        #1 check("after_rst_respawn_req", respawn_req, 0);
        check("sb_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
